// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad, debounces press and
// release, and issues one key code with a single-cycle strobe per keystroke.
// The FSM holds the row drive on the pressed row from detection until the
// release is accepted, so the same key keeps being observed throughout.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       pressed,
    output logic       held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync_q, sync_d;
    logic [3:0]      cs_q, cs_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [BW-1:0]   deb_q, deb_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      pat_q, pat_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      key_q, key_d;
    logic            pressed_q, pressed_d;
    logic            held_q, held_d;
    logic [1:0]      next_idx;
    logic [1:0]      low_col;

    // Active-low one-hot-zero drive for a row index.
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        row_drive = ~(4'b0001 << idx);
    endfunction

    // Next-state logic: synchroniser shift, scan rotation, debounce and release counting.
    always_comb begin
        state_d   = state_q;
        sync_d    = col;
        cs_d      = sync_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        row_idx_d = row_idx_q;
        row_d     = row_q;
        pat_d     = pat_q;
        col_idx_d = col_idx_q;
        key_d     = key_q;
        pressed_d = 1'b0;
        held_d    = held_q;
        next_idx  = row_idx_q + 2'd1;

        // Multiple keys on one row: the lowest column wins.
        if (!cs_q[0])      low_col = 2'd0;
        else if (!cs_q[1]) low_col = 2'd1;
        else if (!cs_q[2]) low_col = 2'd2;
        else               low_col = 2'd3;

        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (cs_q != 4'hF) begin
                        pat_d     = cs_q;
                        col_idx_d = low_col;
                        deb_d     = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = next_idx;
                        row_d     = row_drive(next_idx);
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (cs_q == pat_q) begin
                    if (deb_q == DEB_LAST) begin
                        key_d   = {row_idx_q, col_idx_q};
                        state_d = ST_EMIT;
                    end else begin
                        deb_d = deb_q + BW'(1);
                    end
                end else begin
                    // Pattern changed before it was stable long enough: treat as bounce.
                    state_d   = ST_SCAN;
                    row_idx_d = next_idx;
                    row_d     = row_drive(next_idx);
                    dwell_d   = '0;
                end
            end
            ST_EMIT: begin
                pressed_d = 1'b1;
                held_d    = 1'b1;
                deb_d     = '0;
                state_d   = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cs_q == 4'hF) begin
                    if (deb_q == DEB_LAST) begin
                        held_d    = 1'b0;
                        row_idx_d = 2'd0;
                        row_d     = 4'b1110;
                        dwell_d   = '0;
                        state_d   = ST_SCAN;
                    end else begin
                        deb_d = deb_q + BW'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_SCAN;
            sync_q    <= 4'hF;
            cs_q      <= 4'hF;
            dwell_q   <= '0;
            deb_q     <= '0;
            row_idx_q <= 2'd0;
            row_q     <= 4'b1110;
            pat_q     <= 4'hF;
            col_idx_q <= 2'd0;
            key_q     <= 4'h0;
            pressed_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cs_q      <= cs_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            row_idx_q <= row_idx_d;
            row_q     <= row_d;
            pat_q     <= pat_d;
            col_idx_q <= col_idx_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
            held_q    <= held_d;
        end
    end

    assign row     = row_q;
    assign key     = key_q;
    assign pressed = pressed_q;
    assign held    = held_q;

endmodule
